// File: rtl/imem_server.sv
// Multi-thread instruction ROM: one single-port array shared by NUM_Threads
// fetch ports through per-thread line buffers and a round-robin read arbiter.
module imem_server #(
   parameter int NUM_Threads = 4,
   parameter int ADDR_W      = 10
) (
   input  logic                   clki,
   input  logic                   rsti,
   input  logic [31:0]            pc2rom    [NUM_Threads-1:0],
   output logic [31:0]            rom_ins   [NUM_Threads-1:0],
   output logic [NUM_Threads-1:0] ins_valid,
   input  logic                   load_en,
   input  logic [ADDR_W-1:0]      load_addr,
   input  logic [31:0]            load_data
);
   localparam int          TW  = (NUM_Threads > 1) ? $clog2(NUM_Threads) : 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]            r_mem  [2**ADDR_W];
   logic [31:0]            r_tag  [NUM_Threads];
   logic [31:0]            r_data [NUM_Threads];
   logic [NUM_Threads-1:0] r_bvld;
   logic [TW-1:0]          r_ptr;
   logic                   r_rd_vld;
   logic                   r_rd_oor;
   logic [TW-1:0]          r_rd_tid;
   logic [31:0]            r_rd_pc;
   logic [31:0]            r_rd_data;

   logic [NUM_Threads-1:0] w_hit;
   logic [NUM_Threads-1:0] w_fill;
   logic [NUM_Threads-1:0] w_pend;
   logic [NUM_Threads-1:0] w_bvld_nxt;
   logic [31:0]            w_tag_nxt [NUM_Threads];
   logic                   w_gnt_vld;
   logic [TW-1:0]          w_gnt_id;
   logic [31:0]            w_gnt_pc;

   always_comb begin
      w_hit  = '0;
      w_fill = '0;
      w_pend = '0;
      for (int k = 0; k < NUM_Threads; k++) begin
         w_hit[k]  = r_bvld[k] && (r_tag[k] == pc2rom[k]);
         w_fill[k] = r_rd_vld && (int'(r_rd_tid) == k);
         w_pend[k] = !w_hit[k] && !w_fill[k];
      end
   end

   // Round-robin search starting at r_ptr; a load owns the array this cycle.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = '0;
      for (int i = 0; i < NUM_Threads; i++) begin
         if (!w_gnt_vld && !load_en && w_pend[(int'(r_ptr) + i) % NUM_Threads]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = TW'((int'(r_ptr) + i) % NUM_Threads);
         end
      end
      w_gnt_pc = pc2rom[w_gnt_id];
   end

   // Fill first, then invalidate, so a load hitting a completing read wins.
   always_comb begin
      w_bvld_nxt = '0;
      for (int k = 0; k < NUM_Threads; k++) begin
         w_tag_nxt[k]  = w_fill[k] ? r_rd_pc : r_tag[k];
         w_bvld_nxt[k] = w_fill[k] | r_bvld[k];
         if (load_en && (w_tag_nxt[k][ADDR_W+1:2] == load_addr) &&
             (w_tag_nxt[k][31:ADDR_W+2] == '0))
            w_bvld_nxt[k] = 1'b0;
      end
   end

   always_ff @(posedge clki) begin
      if (load_en && !rsti)
         r_mem[load_addr] <= load_data;
      if (w_gnt_vld) begin
         r_rd_data <= r_mem[w_gnt_pc[ADDR_W+1:2]];
         r_rd_tid  <= w_gnt_id;
         r_rd_pc   <= w_gnt_pc;
         r_rd_oor  <= |w_gnt_pc[31:ADDR_W+2];
      end
   end

   always_ff @(posedge clki) begin
      if (rsti) begin
         r_rd_vld <= 1'b0;
         r_ptr    <= '0;
         r_bvld   <= '0;
         for (int k = 0; k < NUM_Threads; k++) begin
            r_tag[k]  <= '0;
            r_data[k] <= NOP;
         end
      end else begin
         r_rd_vld <= w_gnt_vld;
         if (w_gnt_vld)
            r_ptr <= TW'((int'(w_gnt_id) + 1) % NUM_Threads);
         r_bvld <= w_bvld_nxt;
         for (int k = 0; k < NUM_Threads; k++) begin
            r_tag[k] <= w_tag_nxt[k];
            if (w_fill[k])
               r_data[k] <= r_rd_oor ? NOP : r_rd_data;
         end
      end
   end

   always_comb begin
      ins_valid = '0;
      for (int k = 0; k < NUM_Threads; k++) begin
         ins_valid[k] = w_hit[k];
         rom_ins[k]   = w_hit[k] ? r_data[k] : NOP;
      end
   end

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server: single fetch, round-robin order, load
// invalidate, pc change in flight, out-of-range fill and mid-flight reset.
module tb_imem_server;
   localparam int          N   = 4;
   localparam int          AW  = 10;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clki = 1'b0;
   logic          rsti = 1'b1;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [31:0]   load_data = '0;
   logic [31:0]   pc2rom  [N-1:0];
   logic [31:0]   rom_ins [N-1:0];
   logic [N-1:0]  ins_valid;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0] ld_a [5] = '{10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
   logic [31:0]   ld_d [5] = '{32'h00500093, 32'h11111111, 32'h22222222,
                               32'hAAAA0008, 32'h33333333};

   always #5 clki = ~clki;

   imem_server #(.NUM_Threads(N), .ADDR_W(AW)) u_dut (
      .clki      (clki),
      .rsti      (rsti),
      .pc2rom    (pc2rom),
      .rom_ins   (rom_ins),
      .ins_valid (ins_valid),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clki);
      #1;
   endtask

   task automatic chk_vld(input string tag, input logic [3:0] exp);
      check(tag, {28'd0, ins_valid}, {28'd0, exp});
   endtask

   initial begin
      for (int k = 0; k < N; k++) pc2rom[k] = 32'h0;
      cyc();
      cyc();
      chk_vld("rst_vld", 4'b0000);
      for (int k = 0; k < N; k++) check($sformatf("rst_ins%0d", k), rom_ins[k], NOP);

      rsti    = 1'b0;
      load_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         load_addr = ld_a[i];
         load_data = ld_d[i];
         cyc();
      end

      // cycle 0: all four threads request at once
      load_en   = 1'b0;
      pc2rom[0] = 32'h14;
      pc2rom[1] = 32'h18;
      pc2rom[2] = 32'h1C;
      pc2rom[3] = 32'h20;
      chk_vld("c0_vld", 4'b0000); cyc();
      chk_vld("c1_vld", 4'b0000); cyc();
      chk_vld("c2_vld", 4'b0001); check("c2_ins0", rom_ins[0], 32'h00500093); cyc();
      chk_vld("c3_vld", 4'b0011); check("c3_ins1", rom_ins[1], 32'h11111111); cyc();
      chk_vld("c4_vld", 4'b0111); check("c4_ins2", rom_ins[2], 32'h22222222); cyc();
      chk_vld("c5_vld", 4'b1111); check("c5_ins3", rom_ins[3], 32'hAAAA0008); cyc();

      // thread 1 moves to word 8, then word 8 is reloaded while thread 0 waits
      chk_vld("c6_vld", 4'b1111); pc2rom[1] = 32'h20; cyc();
      chk_vld("c7_vld", 4'b1101); cyc();
      chk_vld("c8_vld", 4'b1111); check("c8_ins1", rom_ins[1], 32'hAAAA0008);
      load_en   = 1'b1;
      load_addr = 10'd8;
      load_data = 32'h00100113;
      pc2rom[0] = 32'h24;
      cyc();
      load_en = 1'b0;
      chk_vld("c9_vld", 4'b0100); cyc();
      chk_vld("c10_vld", 4'b0100); cyc();
      chk_vld("c11_vld", 4'b1100); check("c11_ins3", rom_ins[3], 32'h00100113); cyc();
      chk_vld("c12_vld", 4'b1101); check("c12_ins0", rom_ins[0], 32'h33333333); cyc();
      chk_vld("c13_vld", 4'b1111); check("c13_ins1", rom_ins[1], 32'h00100113);

      // thread 2 pc changes the cycle after its grant
      pc2rom[2] = 32'h20; cyc();
      chk_vld("c14_vld", 4'b1011); pc2rom[2] = 32'h24; cyc();
      chk_vld("c15_vld", 4'b1011); check("c15_ins2", rom_ins[2], NOP); cyc();
      chk_vld("c16_vld", 4'b1011); cyc();
      chk_vld("c17_vld", 4'b1111); check("c17_ins2", rom_ins[2], 32'h33333333);

      // out-of-range pc on thread 3, unaligned pc on thread 0
      pc2rom[3] = 32'h0000_2000;
      pc2rom[0] = 32'h15;
      cyc();
      chk_vld("c18_vld", 4'b0110); cyc();
      chk_vld("c19_vld", 4'b1110); check("c19_ins3", rom_ins[3], NOP); cyc();
      chk_vld("c20_vld", 4'b1111); check("c20_ins0", rom_ins[0], 32'h00500093);

      // reset while thread 1 has a read in flight
      pc2rom[1] = 32'h14; cyc();
      rsti = 1'b1; cyc();
      rsti = 1'b0;
      chk_vld("c22_vld", 4'b0000);
      for (int k = 0; k < N; k++) check($sformatf("c22_ins%0d", k), rom_ins[k], NOP);
      pc2rom[0] = 32'h24;
      pc2rom[2] = 32'h18;
      pc2rom[3] = 32'h1C;
      cyc();
      chk_vld("c23_vld", 4'b0000); cyc();
      chk_vld("c24_vld", 4'b0001); check("c24_ins0", rom_ins[0], 32'h33333333); cyc();
      chk_vld("c25_vld", 4'b0011); check("c25_ins1", rom_ins[1], 32'h00500093);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imem_server.md
IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 SHALL have parameter NUM_Threads, default 4, meaning the number of hardware-thread fetch ports.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the word-address width; the ROM depth is 2^ADDR_W 32-bit words.
REQ-003 SHALL have port clki, input, 1, the single clock.
REQ-004 SHALL have port rsti, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port pc2rom[NUM_Threads-1:0], input, 32 each, the per-thread fetch byte address.
REQ-006 SHALL have port rom_ins[NUM_Threads-1:0], output, 32 each, the per-thread instruction word.
REQ-007 SHALL have port ins_valid[NUM_Threads-1:0], output, 1 each; high means rom_ins[k] matches the current pc2rom[k].
REQ-008 SHALL have port load_en, input, 1, the program-load write strobe.
REQ-009 SHALL have port load_addr, input, ADDR_W, the load word address.
REQ-010 SHALL have port load_data, input, 32, the load write data.

Function
REQ-011 SHALL hold a 2^ADDR_W x 32 single-read-port array; a read is registered (one-cycle), and the array contents are not reset.
REQ-012 SHALL keep one line buffer per thread: tag (32-bit pc), data (32 bits), valid (1 bit).
REQ-013 SHALL treat thread k as pending when its buffer is not a hit (valid=0 or tag!=pc2rom[k]) and thread k has no read in flight.
REQ-014 SHALL grant at most one pending thread per cycle, round-robin: search starts at pointer p; after a grant to thread k, p <= (k+1) mod NUM_Threads; p is unchanged when there is no grant.
REQ-015 SHALL, on a grant to k in cycle t, register the index pc2rom[k][ADDR_W+1:2], the thread id, and the issued pc; the array output is valid in cycle t+1.
REQ-016 SHALL, at the end of cycle t+1, write buffer k with tag = the issued pc, data = the array output, valid=1; ins_valid[k] is first high in cycle t+2 (best-case fetch latency is 2 cycles).
REQ-017 SHALL compute ins_valid[k] = buffer valid AND tag==pc2rom[k] combinationally; the next pending evaluation uses the same compare.
REQ-018 SHALL drive rom_ins[k] = buffer data when ins_valid[k]=1, else 32'h00000013 (NOP).
REQ-019 SHALL ignore pc bits [1:0]; an unaligned pc is served from its containing word.
REQ-020 SHALL, when pc2rom[k][31:ADDR_W+2]!=0 (out of range) on grant, fill buffer k with NOP and valid=1 at the same latency, ignoring the array output.
REQ-021 SHALL, when load_en=1, write load_data to load_addr at the clock edge and issue no grant that cycle.
REQ-022 SHALL, on a load, clear valid on every buffer whose tag[ADDR_W+1:2]==load_addr and whose tag upper bits are 0.
REQ-023 SHALL, when a load hits the word whose in-flight read completes in the same cycle, capture the data and then clear valid (invalidate wins), so the thread re-fetches.
REQ-024 SHALL let an in-flight read complete and fill the buffer even when pc2rom[k] changed meanwhile; the tag mismatch keeps ins_valid low and re-pends the thread.
REQ-025 SHALL let multiple threads with identical pc each fetch independently, with no sharing.

Reset
REQ-026 SHALL, while rsti=1 at an edge: all buffer valid=0, tags=0, data=NOP, p=0, in-flight read dropped, ins_valid all 0, rom_ins all NOP.
REQ-027 SHALL ignore load_en while rsti=1.
REQ-028 SHALL, on the first cycle after reset release with all threads pending, grant thread 0.

Verification
REQ-029 Single fetch: load word 5 = 32'h00500093; pc2rom[0]=32'h14 from cycle 0 -> ins_valid[0]=1 and rom_ins[0]=32'h00500093 in cycle 2.
REQ-030 Round-robin: all 4 threads request different pcs in the same cycle after reset -> grants go to 0,1,2,3 in consecutive cycles; thread 3 is valid in cycle 5.
REQ-031 Load priority and invalidate: thread 1 hits on word 8; load_en to addr 8 with 32'h00100113 -> no grant that cycle, ins_valid[1] drops next cycle, and a re-fetch returns 32'h00100113.
REQ-032 PC change mid-flight: thread 2 pc changes from 0x20 to 0x24 the cycle after its grant -> the 0x20 fill does not raise ins_valid; 0x24 is re-granted and becomes valid.
REQ-033 Out of range: pc2rom[3]=32'h0000_2000 (ADDR_W=10) -> rom_ins[3]=32'h00000013, ins_valid[3]=1 in 2 cycles.
REQ-034 Reset mid-operation: assert rsti during an in-flight read -> no buffer fill, all outputs are reset values the next cycle, and the first post-reset grant is thread 0.
